// File: rtl/frame_load_ctrl_pkg.sv
// Shared types and sizing helpers for the frame load controller.
// Counter widths never collapse to zero bits, even for a one-line frame.
package frame_load_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ARM  = 2'd1,
      LOAD = 2'd2,
      DONE = 2'd3
   } state_t;

   typedef logic [23:0] pixel_t;

   localparam int unsigned FIFO_CNT_W = 10;
   localparam int unsigned IMG_W_DEF  = 320;
   localparam int unsigned IMG_H_DEF  = 240;

   function automatic int unsigned cnt_w(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

   localparam int unsigned X_W_DEF = cnt_w(IMG_W_DEF);
   localparam int unsigned Y_W_DEF = cnt_w(IMG_H_DEF);

endpackage

// File: rtl/frame_load_ctrl_if.sv
// Pixel-in / FIFO-write bundle between packer, controller and pixel FIFO.
// master = controller side, slave = packer/FIFO side.
interface frame_load_ctrl_if;
   import frame_load_pkg::*;

   logic                  pixel_ready;
   pixel_t                pixel_rgb;
   logic [FIFO_CNT_W-1:0] fifo_write_count;
   logic                  fifo_full;
   logic                  fifo_wr_en;
   pixel_t                fifo_din;

   modport master (
      input  pixel_ready,
      input  pixel_rgb,
      input  fifo_write_count,
      input  fifo_full,
      output fifo_wr_en,
      output fifo_din
   );

   modport slave (
      output pixel_ready,
      output pixel_rgb,
      output fifo_write_count,
      output fifo_full,
      input  fifo_wr_en,
      input  fifo_din
   );

endinterface

// File: rtl/frame_load_ctrl_rx_gap_timer.sv
// Counts consecutive cycles without a received byte while run is high.
// expired flags the cycle whose count would reach LIMIT; a byte that cycle wins.
module rx_gap_timer #(
   parameter int unsigned LIMIT = 100000
) (
   input  logic clk,
   input  logic reset,
   input  logic run,
   input  logic rx_ready,
   output logic expired
);

   localparam int unsigned CW = $clog2(LIMIT + 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q + CW'(1);
      if (!run || rx_ready) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired = run && !rx_ready && (cnt_q == CW'(LIMIT - 1));

endmodule

// File: rtl/frame_load_ctrl.sv
// Frame load sequencer: arms the packer, forwards pixels to the FIFO, tracks x/y.
// Optional byte-gap timeout is compiled in with FRAME_LOAD_TIMEOUT_EN.
module frame_load_ctrl
   import frame_load_pkg::*;
#(
   parameter int unsigned IMG_W       = IMG_W_DEF,
   parameter int unsigned IMG_H       = IMG_H_DEF,
   parameter int unsigned FIFO_DEPTH  = 1024,
   parameter int unsigned HIGH_WM     = 1000,
   parameter int unsigned TIMEOUT_CYC = 100000
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      start,
   input  logic                      rx_ready,
   frame_load_ctrl_if.master         bus,
   output logic                      packer_reset,
   output logic                      cts,
   output logic [cnt_w(IMG_W)-1:0]   x_cnt,
   output logic [cnt_w(IMG_H)-1:0]   y_cnt,
   output logic                      busy,
   output logic                      frame_done,
   output logic                      err_overflow,
   output logic                      err_timeout
);

   localparam int unsigned XW = cnt_w(IMG_W);
   localparam int unsigned YW = cnt_w(IMG_H);

   state_t        state_q, state_d;
   logic [XW-1:0] x_q, x_d;
   logic [YW-1:0] y_q, y_d;
   logic          wr_en_q, wr_en_d;
   pixel_t        din_q, din_d;
   logic          pkr_q, pkr_d;
   logic          cts_q, cts_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          err_ov_q, err_ov_d;
   logic          err_to_q, err_to_d;
   logic          loading;
   logic          gap_expired;
   logic          unused_depth;

   assign loading      = (state_q == LOAD);
   assign unused_depth = (FIFO_DEPTH == 0);

`ifdef FRAME_LOAD_TIMEOUT_EN
   rx_gap_timer #(
      .LIMIT (TIMEOUT_CYC)
   ) u_rx_gap_timer (
      .clk      (clk),
      .reset    (reset),
      .run      (loading),
      .rx_ready (rx_ready),
      .expired  (gap_expired)
   );
`else
   logic unused_rx;
   assign unused_rx   = rx_ready ^ (TIMEOUT_CYC == 0);
   assign gap_expired = 1'b0;
`endif

   always_comb begin
      state_d  = state_q;
      x_d      = x_q;
      y_d      = y_q;
      wr_en_d  = 1'b0;
      din_d    = din_q;
      pkr_d    = 1'b0;
      err_ov_d = err_ov_q;
      err_to_d = err_to_q;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d  = ARM;
               x_d      = '0;
               y_d      = '0;
               err_ov_d = 1'b0;
               err_to_d = 1'b0;
            end
         end
         ARM: begin
            state_d = LOAD;
         end
         LOAD: begin
            // A byte-gap timeout discards any pixel arriving in the same cycle.
            if (gap_expired) begin
               state_d  = IDLE;
               err_to_d = 1'b1;
               pkr_d    = 1'b1;
            end else if (bus.pixel_ready) begin
               if (bus.fifo_full) begin
                  state_d  = IDLE;
                  err_ov_d = 1'b1;
               end else begin
                  wr_en_d = 1'b1;
                  din_d   = bus.pixel_rgb;
                  if (x_q == XW'(IMG_W - 1)) begin
                     x_d = '0;
                     if (y_q == YW'(IMG_H - 1)) begin
                        y_d     = '0;
                        state_d = DONE;
                     end else begin
                        y_d = y_q + YW'(1);
                     end
                  end else begin
                     x_d = x_q + XW'(1);
                  end
               end
            end
         end
         DONE: begin
            state_d = IDLE;
            x_d     = '0;
            y_d     = '0;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Status outputs are decoded from the next state so they line up with it.
      pkr_d  = pkr_d || (state_d == ARM);
      busy_d = (state_d == ARM) || (state_d == LOAD);
      cts_d  = (state_d == LOAD) && (bus.fifo_write_count < FIFO_CNT_W'(HIGH_WM));
      done_d = (state_d == DONE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         x_q      <= '0;
         y_q      <= '0;
         wr_en_q  <= 1'b0;
         din_q    <= '0;
         pkr_q    <= 1'b0;
         cts_q    <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         err_ov_q <= 1'b0;
         err_to_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         x_q      <= x_d;
         y_q      <= y_d;
         wr_en_q  <= wr_en_d;
         din_q    <= din_d;
         pkr_q    <= pkr_d;
         cts_q    <= cts_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         err_ov_q <= err_ov_d;
         err_to_q <= err_to_d;
      end
   end

   assign bus.fifo_wr_en = wr_en_q;
   assign bus.fifo_din   = din_q;
   assign packer_reset   = pkr_q;
   assign cts            = cts_q;
   assign x_cnt          = x_q;
   assign y_cnt          = y_q;
   assign busy           = busy_q;
   assign frame_done     = done_q;
   assign err_overflow   = err_ov_q;
   assign err_timeout    = err_to_q;

endmodule

// File: tb/tb_frame_load_ctrl.sv
// Self-checking bench for frame_load_ctrl: vector table, directed corner cases,
// and random traffic against a pixel-index reference model.
module tb_frame_load_ctrl;
   import frame_load_pkg::*;

   localparam int unsigned IMG_W       = 4;
   localparam int unsigned IMG_H       = 2;
   localparam int unsigned HIGH_WM     = 6;
   localparam int unsigned TIMEOUT_CYC = 50;
`ifdef FRAME_LOAD_TIMEOUT_EN
   localparam bit TMO_EN = 1'b1;
`else
   localparam bit TMO_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic       st;
   logic       rx;
   logic       packer_reset, cts, busy, frame_done, err_overflow, err_timeout;
   logic [1:0] x_cnt;
   logic [0:0] y_cnt;

   frame_load_ctrl_if bus();

   frame_load_ctrl #(
      .IMG_W       (IMG_W),
      .IMG_H       (IMG_H),
      .FIFO_DEPTH  (1024),
      .HIGH_WM     (HIGH_WM),
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) dut (
      .clk          (clk),
      .reset        (rst),
      .start        (st),
      .rx_ready     (rx),
      .bus          (bus),
      .packer_reset (packer_reset),
      .cts          (cts),
      .x_cnt        (x_cnt),
      .y_cnt        (y_cnt),
      .busy         (busy),
      .frame_done   (frame_done),
      .err_overflow (err_overflow),
      .err_timeout  (err_timeout)
   );

   always #5 clk = ~clk;

   int n_pass  = 0;
   int n_total = 0;

   // Reference model: pixel index within the frame plus arm/load flags.
   bit     m_arm, m_load;
   int     m_pix, m_gap;
   bit     e_wr, e_pkr, e_done, e_busy, e_cts, e_errov, e_errto, din_zero;
   pixel_t e_din;

   typedef struct {
      bit     st;
      bit     pr;
      pixel_t rgb;
      bit     full;
      int     cnt;
      bit     wr;
      pixel_t din;
      int     x;
      int     y;
      bit     busy;
      bit     done;
      bit     cts;
      bit     pkr;
   } vec_t;

   vec_t tv[16];

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endfunction

   task automatic model_update();
      bit was_done;
      bit hit;
      was_done = e_done;
      e_wr     = 1'b0;
      e_pkr    = 1'b0;
      e_done   = 1'b0;
      din_zero = 1'b0;
      if (rst) begin
         m_arm = 0; m_load = 0; m_pix = 0; m_gap = 0;
         e_errov = 0; e_errto = 0; e_din = '0; din_zero = 1'b1;
         e_busy = 0; e_cts = 0;
      end else begin
         if (m_arm) begin
            m_arm = 0; m_load = 1; m_gap = 0;
         end else if (m_load) begin
            hit   = TMO_EN && !rx && (m_gap + 1 >= int'(TIMEOUT_CYC));
            m_gap = rx ? 0 : m_gap + 1;
            if (hit) begin
               m_load = 0; e_errto = 1; e_pkr = 1;
            end else if (bus.pixel_ready) begin
               if (bus.fifo_full) begin
                  m_load = 0; e_errov = 1;
               end else begin
                  e_wr = 1; e_din = bus.pixel_rgb; m_pix++;
                  if (m_pix == int'(IMG_W * IMG_H)) begin
                     m_pix = 0; m_load = 0; e_done = 1;
                  end
               end
            end
         end else if (!was_done && st) begin
            m_arm = 1; m_pix = 0; e_errov = 0; e_errto = 0; e_pkr = 1;
         end
         e_busy = m_arm || m_load;
         e_cts  = m_load && (int'(bus.fifo_write_count) < int'(HIGH_WM));
      end
   endtask

   task automatic compare_all();
      chk("fifo_wr_en", 32'(bus.fifo_wr_en), 32'(e_wr));
      if (e_wr || din_zero) chk("fifo_din", 32'(bus.fifo_din), 32'(e_din));
      chk("packer_reset", 32'(packer_reset), 32'(e_pkr));
      chk("cts", 32'(cts), 32'(e_cts));
      chk("x_cnt", 32'(x_cnt), 32'(m_pix % int'(IMG_W)));
      chk("y_cnt", 32'(y_cnt), 32'(m_pix / int'(IMG_W)));
      chk("busy", 32'(busy), 32'(e_busy));
      chk("frame_done", 32'(frame_done), 32'(e_done));
      chk("err_overflow", 32'(err_overflow), 32'(e_errov));
      chk("err_timeout", 32'(err_timeout), 32'(e_errto));
   endtask

   task automatic step();
      @(posedge clk);
      model_update();
      #1;
      compare_all();
   endtask

   task automatic drive(input bit s, input bit p, input pixel_t d, input bit f, input int c, input bit r);
      st                   = s;
      bus.pixel_ready      = p;
      bus.pixel_rgb        = d;
      bus.fifo_full        = f;
      bus.fifo_write_count = 10'(c);
      rx                   = r;
      step();
   endtask

   task automatic idle_cycle();
      drive(1'b0, 1'b0, '0, 1'b0, 0, 1'b0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      idle_cycle();
      rst = 1'b0;
   endtask

   initial begin
      //         st pr rgb  full cnt | wr din   x  y busy done cts pkr
      tv[0]  = '{1, 0, 0,   0,   0,    0, 0,    0, 0, 1,   0,   0,  1};
      tv[1]  = '{0, 0, 0,   0,   0,    0, 0,    0, 0, 1,   0,   1,  0};
      tv[2]  = '{0, 1, 1,   0,   0,    1, 1,    1, 0, 1,   0,   1,  0};
      tv[3]  = '{0, 1, 2,   0,   0,    1, 2,    2, 0, 1,   0,   1,  0};
      tv[4]  = '{0, 0, 0,   0,   0,    0, 0,    2, 0, 1,   0,   1,  0};
      tv[5]  = '{0, 1, 3,   0,   0,    1, 3,    3, 0, 1,   0,   1,  0};
      tv[6]  = '{0, 1, 4,   0,   0,    1, 4,    0, 1, 1,   0,   1,  0};
      tv[7]  = '{0, 1, 5,   0,   5,    1, 5,    1, 1, 1,   0,   1,  0};
      tv[8]  = '{0, 1, 6,   0,   6,    1, 6,    2, 1, 1,   0,   0,  0};
      tv[9]  = '{0, 1, 7,   0,   5,    1, 7,    3, 1, 1,   0,   1,  0};
      tv[10] = '{0, 1, 8,   0,   0,    1, 8,    0, 0, 0,   1,   0,  0};
      tv[11] = '{0, 0, 0,   0,   0,    0, 0,    0, 0, 0,   0,   0,  0};
      tv[12] = '{0, 1, 9,   0,   0,    0, 0,    0, 0, 0,   0,   0,  0};
      tv[13] = '{1, 1, 'hAA,0,   0,    0, 0,    0, 0, 1,   0,   0,  1};
      tv[14] = '{0, 0, 0,   0,   0,    0, 0,    0, 0, 1,   0,   1,  0};
      tv[15] = '{1, 0, 0,   0,   0,    0, 0,    0, 0, 1,   0,   1,  0};

      rst = 1'b1;
      idle_cycle();
      idle_cycle();
      rst = 1'b0;
      chk("reset_busy", 32'(busy), 32'(0));
      chk("reset_din", 32'(bus.fifo_din), 32'(0));

      // Full frame, flow control, ignored start/pixel events.
      for (int i = 0; i < 16; i++) begin
         drive(tv[i].st, tv[i].pr, tv[i].rgb, tv[i].full, tv[i].cnt, 1'b0);
         chk($sformatf("tv%0d_wr", i), 32'(bus.fifo_wr_en), 32'(tv[i].wr));
         if (tv[i].wr) chk($sformatf("tv%0d_din", i), 32'(bus.fifo_din), 32'(tv[i].din));
         chk($sformatf("tv%0d_x", i), 32'(x_cnt), 32'(tv[i].x));
         chk($sformatf("tv%0d_y", i), 32'(y_cnt), 32'(tv[i].y));
         chk($sformatf("tv%0d_busy", i), 32'(busy), 32'(tv[i].busy));
         chk($sformatf("tv%0d_done", i), 32'(frame_done), 32'(tv[i].done));
         chk($sformatf("tv%0d_cts", i), 32'(cts), 32'(tv[i].cts));
         chk($sformatf("tv%0d_pkr", i), 32'(packer_reset), 32'(tv[i].pkr));
      end

      // Overflow on the third pixel, then a fresh start clears the flag.
      drive(1'b0, 1'b1, 24'h000011, 1'b0, 0, 1'b0);
      drive(1'b0, 1'b1, 24'h000022, 1'b0, 0, 1'b0);
      drive(1'b0, 1'b1, 24'h000033, 1'b1, 0, 1'b0);
      chk("ovf_no_write", 32'(bus.fifo_wr_en), 32'(0));
      chk("ovf_flag", 32'(err_overflow), 32'(1));
      chk("ovf_idle", 32'(busy), 32'(0));
      idle_cycle();
      chk("ovf_sticky", 32'(err_overflow), 32'(1));
      drive(1'b1, 1'b0, '0, 1'b0, 0, 1'b0);
      chk("ovf_clear", 32'(err_overflow), 32'(0));
      chk("ovf_rearm_pkr", 32'(packer_reset), 32'(1));

      // Reset after five pixels, then a clean frame from (0,0).
      idle_cycle();
      for (int k = 1; k <= 5; k++) drive(1'b0, 1'b1, pixel_t'(k), 1'b0, 0, 1'b0);
      rst = 1'b1;
      drive(1'b0, 1'b1, 24'h0000FF, 1'b0, 0, 1'b0);
      rst = 1'b0;
      chk("rst_wr", 32'(bus.fifo_wr_en), 32'(0));
      chk("rst_din", 32'(bus.fifo_din), 32'(0));
      chk("rst_x", 32'(x_cnt), 32'(0));
      chk("rst_busy", 32'(busy), 32'(0));
      chk("rst_pkr", 32'(packer_reset), 32'(0));
      drive(1'b1, 1'b0, '0, 1'b0, 0, 1'b0);
      idle_cycle();
      for (int k = 1; k <= 8; k++) drive(1'b0, 1'b1, pixel_t'(24'h100 + k), 1'b0, 0, 1'b0);
      chk("rst_frame_done", 32'(frame_done), 32'(1));
      chk("rst_frame_din", 32'(bus.fifo_din), 32'(24'h108));
      idle_cycle();

      // Byte-gap timeout.
      drive(1'b1, 1'b0, '0, 1'b0, 0, 1'b0);
      idle_cycle();
`ifdef FRAME_LOAD_TIMEOUT_EN
      for (int k = 1; k <= int'(TIMEOUT_CYC); k++) begin
         idle_cycle();
         if (k == int'(TIMEOUT_CYC) - 1) chk("tmo_not_early", 32'(err_timeout), 32'(0));
      end
      chk("tmo_flag", 32'(err_timeout), 32'(1));
      chk("tmo_pkr", 32'(packer_reset), 32'(1));
      chk("tmo_idle", 32'(busy), 32'(0));
      drive(1'b1, 1'b0, '0, 1'b0, 0, 1'b0);
      idle_cycle();
      for (int k = 0; k < 150; k++) drive(1'b0, 1'b0, '0, 1'b0, 0, (k % 49) == 48);
      chk("tmo_kept_alive", 32'(err_timeout), 32'(0));
      chk("tmo_still_busy", 32'(busy), 32'(1));
`else
      for (int k = 0; k < 120; k++) idle_cycle();
      chk("notmo_flag", 32'(err_timeout), 32'(0));
      chk("notmo_busy", 32'(busy), 32'(1));
`endif
      do_reset();

      // Random traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         rst = ($urandom_range(0, 199) == 0);
         drive($urandom_range(0, 15) == 0, $urandom_range(0, 1) == 1, pixel_t'($urandom),
               $urandom_range(0, 15) == 0, int'($urandom_range(0, 10)),
               int'($urandom_range(0, 99)) < (((i / 150) % 2) != 0 ? 30 : 1));
      end
      rst = 1'b0;
      idle_cycle();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
